// File: rtl/contador_param.sv
// contador_param: multi-mode counter (up, down, down-by-3, load) with carry pulses and wrap stats
module contador_param #(
    parameter int WIDTH  = 16,
    parameter int WRAP_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 ENB,
    input  logic [1:0]           MODO,
    input  logic [WIDTH-1:0]     D,
    output logic [WIDTH-1:0]     Q,
    output logic                 RCO,
    output logic [WIDTH/4-1:0]   RCO_SEG,
    output logic                 OVF,
    output logic [WRAP_W-1:0]    WRAPS
);
    localparam int NSEG = WIDTH / 4;

    logic [WIDTH-1:0]  q_q, q_d;
    logic [NSEG-1:0]   seg_q, seg_d, seg_c;
    logic              ovf_q, ovf_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;
    logic              wrap;

    // Carry/borrow out of bit 4i+3 depends only on the low 4i+4 bits
    for (genvar i = 0; i < NSEG; i++) begin : g_seg
        localparam int M = 4 * i + 4;
        logic [M-1:0] lo;
        assign lo = q_q[M-1:0];
        assign seg_c[i] = (MODO == 2'b00) ? &lo :
                          (MODO == 2'b01) ? ~|lo :
                          (MODO == 2'b10) ? (lo < M'(3)) : 1'b0;
    end

    assign wrap = seg_c[NSEG-1];

    always_comb begin
        q_d     = q_q;
        seg_d   = '0;
        ovf_d   = ovf_q;
        wraps_d = wraps_q;
        if (ENB) begin
            q_d     = (MODO == 2'b00) ? q_q + WIDTH'(1) :
                      (MODO == 2'b01) ? q_q - WIDTH'(1) :
                      (MODO == 2'b10) ? q_q - WIDTH'(3) : D;
            seg_d   = seg_c;
            ovf_d   = (MODO == 2'b11) ? 1'b0 : (ovf_q | wrap);
            wraps_d = (MODO == 2'b11) ? '0 :
                      (wrap && !(&wraps_q)) ? wraps_q + WRAP_W'(1) : wraps_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_q     <= '0;
            seg_q   <= '0;
            ovf_q   <= 1'b0;
            wraps_q <= '0;
        end else begin
            q_q     <= q_d;
            seg_q   <= seg_d;
            ovf_q   <= ovf_d;
            wraps_q <= wraps_d;
        end
    end

    assign Q       = q_q;
    assign RCO     = seg_q[NSEG-1];
    assign RCO_SEG = seg_q;
    assign OVF     = ovf_q;
    assign WRAPS   = wraps_q;
endmodule

// File: tb/tb_contador_param.sv
// tb_contador_param: directed checks of contador_param with WIDTH=16, WRAP_W=2
module tb_contador_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enb = 1'b0;
    logic [1:0]  modo = 2'b00;
    logic [15:0] d = '0;
    logic [15:0] q;
    logic        rco;
    logic [3:0]  rco_seg;
    logic        ovf;
    logic [1:0]  wraps;
    int          n_chk = 0;
    int          n_err = 0;

    contador_param #(.WIDTH(16), .WRAP_W(2)) dut (
        .CLK(clk), .RST_N(rst_n), .ENB(enb), .MODO(modo), .D(d),
        .Q(q), .RCO(rco), .RCO_SEG(rco_seg), .OVF(ovf), .WRAPS(wraps)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic e, input logic [1:0] m, input logic [15:0] v);
        enb = e;
        modo = m;
        d = v;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_q", q, 0); chk("rst_rco", rco, 0); chk("rst_seg", rco_seg, 0);
        chk("rst_ovf", ovf, 0); chk("rst_wraps", wraps, 0);
        step(1);
        rst_n = 1'b1;
        drive(1, 2'b00, 16'h0);
        step(3);
        chk("up3_q", q, 16'h0003); chk("up3_rco", rco, 0);
        drive(1, 2'b11, 16'hFFFE); step(1);
        chk("ld_fffe", q, 16'hFFFE);
        drive(1, 2'b00, 16'h0); step(1);
        chk("up_ffff_q", q, 16'hFFFF); chk("up_ffff_rco", rco, 0); chk("up_ffff_seg", rco_seg, 0);
        step(1);
        chk("wrap_q", q, 16'h0000); chk("wrap_rco", rco, 1); chk("wrap_seg", rco_seg, 4'hF);
        chk("wrap_ovf", ovf, 1); chk("wrap_wraps", wraps, 1);
        step(1);
        chk("post_rco", rco, 0); chk("post_seg", rco_seg, 0); chk("post_q", q, 16'h0001);
        chk("post_ovf", ovf, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_q", q, 0); chk("async_ovf", ovf, 0); chk("async_wraps", wraps, 0);
        step(1);
        chk("held_rst_q", q, 0);
        rst_n = 1'b1;
        drive(1, 2'b11, 16'h00FF); step(1);
        drive(1, 2'b00, 16'h0); step(1);
        chk("nib_q", q, 16'h0100); chk("nib_seg", rco_seg, 4'b0011);
        chk("nib_rco", rco, 0); chk("nib_ovf", ovf, 0);
        drive(1, 2'b11, 16'h0010); step(1);
        drive(1, 2'b01, 16'h0); step(1);
        chk("dn_q", q, 16'h000F); chk("dn_seg", rco_seg, 4'b0001); chk("dn_rco", rco, 0);
        drive(1, 2'b11, 16'h0101); step(1);
        drive(1, 2'b10, 16'h0); step(1);
        chk("d3p_q", q, 16'h00FE); chk("d3p_seg", rco_seg, 4'b0011);
        drive(1, 2'b11, 16'h0002); step(1);
        drive(1, 2'b10, 16'h0); step(1);
        chk("d3_q", q, 16'hFFFF); chk("d3_rco", rco, 1); chk("d3_seg", rco_seg, 4'hF);
        drive(0, 2'b10, 16'h0); step(1);
        chk("hold_rco", rco, 0); chk("hold_seg", rco_seg, 0); chk("hold_q1", q, 16'hFFFF);
        step(3);
        chk("hold_q4", q, 16'hFFFF); chk("hold_ovf", ovf, 1); chk("hold_wraps", wraps, 1);
        chk("hold_rco4", rco, 0);
        drive(1, 2'b10, 16'h0); step(1);
        chk("d3b_q", q, 16'hFFFC); chk("d3b_rco", rco, 0);
        drive(1, 2'b11, 16'h1234); step(1);
        chk("ld_q", q, 16'h1234); chk("ld_ovf", ovf, 0); chk("ld_wraps", wraps, 0);
        chk("ld_rco", rco, 0);
        drive(1, 2'b11, 16'h0000); step(1);
        drive(1, 2'b01, 16'h0); step(1);
        chk("s1_q", q, 16'hFFFF); chk("s1_rco", rco, 1); chk("s1_wraps", wraps, 1);
        step(1);
        chk("s2_rco", rco, 0); chk("s2_seg", rco_seg, 0);
        step(2);
        chk("s4_q", q, 16'hFFFC); chk("s4_rco", rco, 0); chk("s4_wraps", wraps, 1);
        drive(1, 2'b00, 16'h0); step(4);
        chk("s5_q", q, 16'h0000); chk("s5_rco", rco, 1); chk("s5_wraps", wraps, 2);
        drive(1, 2'b01, 16'h0); step(1);
        chk("s6_rco", rco, 1); chk("s6_wraps", wraps, 3);
        drive(1, 2'b00, 16'h0); step(1);
        chk("s7_q", q, 16'h0000); chk("s7_rco", rco, 1); chk("s7_wraps", wraps, 3);
        drive(1, 2'b01, 16'h0); step(1);
        chk("s8_q", q, 16'hFFFF); chk("s8_wraps", wraps, 3); chk("s8_ovf", ovf, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
